// File: rtl/operand_collector_pkg.sv
// Shared fixed-point constants and collector FSM encoding for the neuron adder datapath.
// The summing stage imports the same constants so both ends agree on the operand format.
package operand_collector_pkg;

  localparam int N_BITS    = 32;
  localparam int INT_BITS  = 12;
  localparam int FRAC_BITS = 20;
  localparam int M_SLOTS   = 8;

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_FULL    = 1'b1;

endpackage

// File: rtl/operand_collector.sv
// Collects up to m fixed-point products into one packed vector and hands it to the
// combinational summing stage over a valid/ready handshake; supports early termination.
module operand_collector
  import operand_collector_pkg::*;
#(
  parameter int m        = M_SLOTS,
  parameter int n        = N_BITS,
  parameter int intbits  = INT_BITS,
  parameter int fracbits = FRAC_BITS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [n-1:0]             in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [n*m-1:0]           operand,
  output logic [$clog2(m+1)-1:0]   elem_cnt
);

  localparam int CNT_W = $clog2(m+1);

  logic [0:0]       state_r;
  logic [0:0]       state_nxt_s;
  logic [n*m-1:0]   operand_r;
  logic [n*m-1:0]   operand_nxt_s;
  logic [CNT_W-1:0] elem_cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             in_ready_s;
  logic             accept_s;
  logic             close_s;
  logic [m-1:0]     slot_we_s;

  // rst_n gates ready so the producer sees a stall for the whole time reset is held
  assign in_ready_s = rst_n && (state_r == ST_COLLECT) && !flush;
  assign accept_s   = in_valid && in_ready_s;
  assign close_s    = accept_s && ((elem_cnt_r == CNT_W'(m - 1)) || in_last);

  assign in_ready  = in_ready_s;
  assign out_valid = (state_r == ST_FULL);
  assign operand   = operand_r;
  assign elem_cnt  = elem_cnt_r;

  // Decoded per-slot write enable: the next free slot is the one indexed by elem_cnt
  always_comb begin
    slot_we_s = '0;
    for (int k = 0; k < m; k++) begin
      if (accept_s && (elem_cnt_r == CNT_W'(k))) begin
        slot_we_s[k] = 1'b1;
      end else begin
        slot_we_s[k] = 1'b0;
      end
    end
  end

  // Next-state logic: flush outranks both accept and the output handshake
  always_comb begin
    state_nxt_s   = state_r;
    operand_nxt_s = operand_r;
    cnt_nxt_s     = elem_cnt_r;
    if (flush) begin
      state_nxt_s   = ST_COLLECT;
      operand_nxt_s = '0;
      cnt_nxt_s     = '0;
    end else begin
      case (state_r)
        ST_COLLECT: begin
          if (accept_s) begin
            for (int k = 0; k < m; k++) begin
              if (slot_we_s[k]) begin
                operand_nxt_s[n*k +: n] = in_data;
              end else begin
                operand_nxt_s[n*k +: n] = operand_r[n*k +: n];
              end
            end
            cnt_nxt_s = elem_cnt_r + CNT_W'(1);
            if (close_s) begin
              state_nxt_s = ST_FULL;
            end else begin
              state_nxt_s = ST_COLLECT;
            end
          end else begin
            state_nxt_s = ST_COLLECT;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            state_nxt_s   = ST_COLLECT;
            operand_nxt_s = '0;
            cnt_nxt_s     = '0;
          end else begin
            state_nxt_s = ST_FULL;
          end
        end
        default: begin
          state_nxt_s   = ST_COLLECT;
          operand_nxt_s = '0;
          cnt_nxt_s     = '0;
        end
      endcase
    end
  end

  // State, vector and count registers; reset discards any partial vector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_COLLECT;
      operand_r  <= '0;
      elem_cnt_r <= '0;
    end else begin
      state_r    <= state_nxt_s;
      operand_r  <= operand_nxt_s;
      elem_cnt_r <= cnt_nxt_s;
    end
  end

endmodule

// File: tb/tb_operand_collector.sv
// Scoreboard bench for operand_collector: a list-of-products model predicts vectors,
// a negedge monitor compares whatever the DUT presents against the expected queue.
module tb_operand_collector;

  localparam int M  = 8;
  localparam int N  = 32;
  localparam int VW = N * M;

  typedef struct {
    logic [VW-1:0] vec;
    int            cnt;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] operand;
  logic [3:0]    elem_cnt;

  int checks = 0;
  int errors = 0;

  exp_t        exp_q[$];
  logic [31:0] cur[$];
  bit          m_full = 0;

  operand_collector dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .operand(operand), .elem_cnt(elem_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] pack_cur();
    logic [VW-1:0] v = '0;
    for (int i = 0; i < cur.size(); i++) v[N*i +: N] = cur[i];
    return v;
  endfunction

  // Monitor: whatever the DUT presents must match the oldest expected vector
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_vector: got %h expected none", operand);
      end else begin
        check("vector_data", operand, exp_q[0].vec);
        check("vector_cnt", VW'(elem_cnt), VW'(exp_q[0].cnt));
        if (out_ready && !flush) exp_q.pop_front();
      end
    end
  end

  // One clock of stimulus, followed by flag checks and the model update for that edge
  task automatic cycle(input logic v, input logic [31:0] d, input logic l,
                       input logic r, input logic f);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
    flush     = f;
    @(negedge clk);
    #1;
    check("in_ready", VW'(in_ready), VW'(!m_full && !f));
    check("out_valid", VW'(out_valid), VW'(m_full));
    if (!m_full) begin
      check("partial_cnt", VW'(elem_cnt), VW'(cur.size()));
      check("partial_vec", operand, pack_cur());
    end
    if (f) begin
      if (m_full) exp_q.delete(exp_q.size() - 1);
      m_full = 0;
      cur.delete();
    end else if (m_full) begin
      if (r) begin
        m_full = 0;
        cur.delete();
      end
    end else if (v) begin
      exp_t e;
      cur.push_back(d);
      if (cur.size() == M || l) begin
        e.vec = pack_cur();
        e.cnt = cur.size();
        exp_q.push_back(e);
        m_full = 1;
      end
    end
  endtask

  task automatic idle(input logic r);
    cycle(1'b0, 32'h0, 1'b0, r, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 32'h0;
    in_last = 1'b0; out_ready = 1'b0;
    #2;
    check("rst_in_ready", VW'(in_ready), VW'(1'b0));
    check("rst_operand", operand, '0);
    check("rst_cnt", VW'(elem_cnt), VW'(0));
    check("rst_out_valid", VW'(out_valid), VW'(1'b0));
    #20 rst_n = 1'b1;

    // Full vector 1.0..8.0, held five cycles before the consumer takes it
    for (int k = 1; k <= 8; k++) cycle(1'b1, 32'(k) << 20, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
    idle(1'b0);

    // Early termination after three products
    cycle(1'b1, 32'hFFF0_0000, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h0020_0000, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h0008_0000, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);

    // Input-side bubbles: only valid cycles are captured
    for (int k = 0; k < 16; k++)
      cycle(k % 2 == 0, 32'hA000_0000 + 32'(k), 1'b0, 1'b0, 1'b0);
    idle(1'b1);

    // Flush mid-collect discards the product presented alongside it
    for (int k = 0; k < 4; k++) cycle(1'b1, 32'h0100_0000 + 32'(k), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) cycle(1'b1, 32'h0200_0000 + 32'(k), 1'b0, 1'b0, 1'b0);
    idle(1'b1);

    // Flush beats handshake in FULL
    for (int k = 0; k < 8; k++) cycle(1'b1, 32'h0300_0000 + 32'(k), 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    idle(1'b1);

    // Asynchronous reset after five accepts
    for (int k = 0; k < 5; k++) cycle(1'b1, 32'h0400_0000 + 32'(k), 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_operand", operand, '0);
    check("arst_cnt", VW'(elem_cnt), VW'(0));
    check("arst_out_valid", VW'(out_valid), VW'(1'b0));
    check("arst_in_ready", VW'(in_ready), VW'(1'b0));
    cur.delete();
    exp_q.delete();
    m_full = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 check("release_in_ready", VW'(in_ready), VW'(1'b1));
    idle(1'b0);

    // Randomised traffic
    for (int k = 0; k < 400; k++)
      cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 7) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0);
    idle(1'b1);
    idle(1'b0);
    check("queue_drained", VW'(exp_q.size()), VW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_collector.md
Name: operand_collector

Overview:
- Producer side of the packed operand bus used by the neuron adder stage.
- Accepts one n-bit Q(intbits).(fracbits) product per handshake from the serial multiplier path.
- Assembles up to m products into an n*m packed vector, then presents it with a valid/ready handshake to the summing stage.
- Provides the buffering, element counting and early-termination logic that the purely combinational summing stage does not have.

Parameters:
- m, 8, number of operand slots per vector
- n, 32, width of one operand in bits
- intbits, 12, integer bits of the fixed-point format (informational, n = intbits + fracbits)
- fracbits, 20, fraction bits of the fixed-point format (informational)

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous discard of the partial or completed vector
- in_valid  input  1  in_data carries a product
- in_ready  output  1  collector can accept a product this cycle
- in_data  input  n  product, two's complement Q12.20
- in_last  input  1  qualifies in_data as the final product of the vector (early termination)
- out_valid  output  1  operand holds a complete vector
- out_ready  input  1  consumer accepts operand this cycle
- operand  output  n*m  packed vector; slot k (1..m) at bits [n*k-1 -: n]
- elem_cnt  output  $clog2(m+1)  number of slots filled in the current vector

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=COLLECT, operand=0, elem_cnt=0, out_valid=0.
  - in_ready goes low while rst_n is low, and is high in the first cycle after release.
  - Reset mid-vector discards all collected data.
- States: COLLECT, FULL.
- in_ready = (state==COLLECT) && !flush. out_valid = (state==FULL), driven from a register.
- Accept = in_valid && in_ready. On accept in COLLECT:
  - in_data is written verbatim (no resize) into slot elem_cnt+1.
  - elem_cnt increments.
  - The first accepted product lands in bits [n-1:0].
- Transition COLLECT->FULL on an accept when elem_cnt==m-1 or in_last==1.
  - out_valid rises the cycle after that accept (1-cycle latency).
  - Unfilled slots remain zero.
- in_last on the m-th product behaves the same as a normal m-th accept.
- in_last with in_valid low is ignored.
- In FULL:
  - in_ready=0.
  - operand and elem_cnt are held stable while out_valid && !out_ready.
- Output handshake (out_valid && out_ready):
  - Next cycle: operand=0, elem_cnt=0, state=COLLECT.
  - No product is accepted in the handshake cycle; sustained throughput is one vector per m+1 cycles.
- flush (synchronous, highest priority over accept and handshake):
  - Next cycle: operand=0, elem_cnt=0, state=COLLECT, out_valid=0.
  - A product presented during the flush cycle is not accepted, because in_ready is already low.
  - Flush in FULL drops the vector even if out_ready is high in the same cycle; that cycle does not count as a transfer.
- No arithmetic is performed; sign and format are passed through untouched. The summing stage owns accumulation and clamping.
- elem_cnt never exceeds m and has no wrap-around path.

Decomposition:
- Shared package: fixed-point constants (N_BITS=32, INT_BITS=12, FRAC_BITS=20, M_SLOTS=8) and the COLLECT/FULL state encoding. The summing stage and this block import the same constants.
- No sub-module. Slot write is a decoded enable per slot; a separate slot-register module adds nothing.

Test Plan:
- Full vector: after reset, stream 8 products 0x00100000..0x00800000 (1.0..8.0), in_valid held high, out_ready=0.
  - in_ready drops after the 8th accept and out_valid rises the next cycle.
  - Slot1=0x00100000, slot8=0x00800000, elem_cnt=8.
  - Vector is held 5 cycles until out_ready=1.
- Early termination: 3 products 0xFFF00000 (-1.0), 0x00200000, 0x00080000, with in_last on the 3rd.
  - out_valid rises; slots 4..8 are 0; elem_cnt=3.
  - After handshake, elem_cnt=0 and operand=0.
- Backpressure on input: toggle in_valid 1,0,1,0 with 8 distinct values.
  - Only valid cycles are captured, in order, with no duplicates or gaps.
- Flush mid-collect: flush asserted after 4 accepts while in_valid=1 with 0x12345678.
  - That value is not accepted; elem_cnt=0 the next cycle.
  - The next 8 products form a clean vector.
- Flush vs handshake: in FULL, assert flush and out_ready together.
  - out_valid=0 the next cycle and operand=0; the consumer must not count the vector.
- Async reset: drop rst_n mid-cycle after 5 accepts.
  - operand, elem_cnt and out_valid clear immediately, without waiting for a clock edge.
  - in_ready is high in the first cycle after release.
